// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage data-memory sequencer.
package mem_access_unit_pkg;

  // MEM_ctrl bit positions, shared with the decoder and the EX/MEM register
  localparam int MEM_CTRL_READ  = 1;
  localparam int MEM_CTRL_WRITE = 0;

  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mau_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  function automatic logic is_word_aligned(input logic [31:0] a);
    return (a[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_unit_timeout_cnt.sv
// Busy-cycle watchdog: counts cycles without ack, flags the last allowed one.
module mem_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign expire = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage sequencer: one req/ack word transfer per instruction, stalls the
// upstream pipeline until the access is done.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [1:0]  MEM_ctrl_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  mau_state_e state;
  logic       drop_q;
  logic       acc, is_wr, start, drop_now, expire;

  assign acc      = MEM_ctrl_i[MEM_CTRL_READ] | MEM_ctrl_i[MEM_CTRL_WRITE];
  assign is_wr    = MEM_ctrl_i[MEM_CTRL_WRITE];
  assign start    = (state == IDLE) && acc && !flush_i;
  assign drop_now = drop_q | flush_i;
  assign stall_o  = start || (state == BUSY);

  mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (start),
    .en     ((state == BUSY) && !mem_ack_i),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      drop_q      <= 1'b0;
      err_o       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rdata_o     <= '0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_word_aligned(addr_i)) begin
              state       <= BUSY;
              drop_q      <= 1'b0;
              mem_req_o   <= 1'b1;
              mem_we_o    <= is_wr;
              // bus is word addressed
              mem_addr_o  <= {2'b00, addr_i[31:2]};
              mem_wdata_o <= wdata_i;
            end else begin
              state <= DONE;
              err_o <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (flush_i) drop_q <= 1'b1;
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            if (!mem_we_o && !drop_now) rdata_o <= mem_rdata_i;
            state <= drop_now ? IDLE : DONE;
          end else if (expire) begin
            mem_req_o <= 1'b0;
            // a squashed instruction leaves no trace, not even an error
            if (drop_now) begin
              state <= IDLE;
            end else begin
              rdata_o <= '0;
              err_o   <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a bus-request scoreboard.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [1:0]  MEM_ctrl_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, err_o, mem_req_o, mem_we_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int n_assert = 0;
  int n_fail   = 0;
  bus_req_t exp_q[$];

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .MEM_ctrl_i  (MEM_ctrl_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .stall_o     (stall_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One instruction through the MEM stage; ack_wait/flush_cyc index BUSY cycles (-1 = never).
  task automatic do_access(input string tag, input logic [1:0] ctrl, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_wait, input logic [31:0] bus_rdata,
                           input int flush_cyc, input int exp_stall, input int exp_err,
                           input logic [31:0] exp_rdata, input int exp_reqs);
    int busy = 0, stall = 0, errs = 0, reqs = 0;
    bit done = 0, stable = 1, prev_req = 0, flushed = 0;
    bus_req_t first = '0;
    if (addr[1:0] == 2'b00) exp_q.push_back('{we: ctrl[0], addr: addr >> 2, wdata: wdata});
    MEM_ctrl_i = ctrl; addr_i = addr; wdata_i = wdata;
    for (int c = 0; c < 64 && !done; c++) begin
      if (mem_req_o) begin
        if (!prev_req) begin
          reqs++;
          if (exp_q.size() != 0) begin
            first = exp_q.pop_front();
            chk({tag, ".we"},    {31'd0, mem_we_o}, {31'd0, first.we});
            chk({tag, ".addr"},  mem_addr_o, first.addr);
            chk({tag, ".wdata"}, mem_wdata_o, first.wdata);
          end
        end else if (mem_we_o !== first.we || mem_addr_o !== first.addr ||
                     mem_wdata_o !== first.wdata) begin
          stable = 0;
        end
        mem_ack_i   = (busy == ack_wait);
        mem_rdata_i = bus_rdata;
        flush_i     = (busy == flush_cyc);
        busy++;
      end else begin
        mem_ack_i = 1'b0; mem_rdata_i = '0; flush_i = 1'b0;
      end
      prev_req = mem_req_o;
      #1;
      if (stall_o) stall++;
      if (err_o) errs++;
      if (flush_i) flushed = 1;
      if (flushed) MEM_ctrl_i = 2'b00;
      if (c > 0 && !stall_o) begin
        done = 1;
        chk({tag, ".rdata"}, rdata_o, exp_rdata);
        MEM_ctrl_i = 2'b00;
      end
      @(posedge clk); #1;
    end
    mem_ack_i = 1'b0; flush_i = 1'b0;
    chk({tag, ".done"},   {31'd0, done}, 32'd1);
    chk({tag, ".stall"},  stall, exp_stall);
    chk({tag, ".err"},    errs, exp_err);
    chk({tag, ".reqs"},   reqs, exp_reqs);
    chk({tag, ".stable"}, {31'd0, stable}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; MEM_ctrl_i = 2'b00; addr_i = '0; wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    #2;
    chk("rst.req",   {31'd0, mem_req_o}, 32'd0);
    chk("rst.stall", {31'd0, stall_o}, 32'd0);
    chk("rst.err",   {31'd0, err_o}, 32'd0);
    chk("rst.rdata", rdata_o, 32'd0);
    chk("rst.addr",  mem_addr_o, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    do_access("lw_fast",  2'b10, 32'h100, 32'h0, 0, 32'hCAFEBABE, -1, 2, 0, 32'hCAFEBABE, 1);
    do_access("sw_wait3", 2'b01, 32'h204, 32'h12345678, 3, 32'hDEADBEEF, -1, 5, 0, 32'hCAFEBABE, 1);
    do_access("lw_misal", 2'b10, 32'h102, 32'h0, 0, 32'h0BADF00D, -1, 1, 1, 32'hCAFEBABE, 0);
    do_access("lw_tmo",   2'b10, 32'h300, 32'h0, -1, 32'h0BADF00D, -1, 17, 1, 32'h0, 1);
    do_access("b2b_lw0",  2'b10, 32'h010, 32'h0, 0, 32'h11111111, -1, 2, 0, 32'h11111111, 1);
    do_access("b2b_lw1",  2'b10, 32'h014, 32'h0, 1, 32'h22222222, -1, 3, 0, 32'h22222222, 1);
    do_access("lw_flush", 2'b10, 32'h400, 32'h0, 2, 32'h000055AA, 1, 4, 0, 32'h22222222, 1);
    do_access("rw_both",  2'b11, 32'h500, 32'hABC, 0, 32'h00000099, -1, 2, 0, 32'h22222222, 1);

    // stray ack while idle must be ignored
    mem_ack_i = 1'b1; mem_rdata_i = 32'h77;
    @(posedge clk); #1; mem_ack_i = 1'b0;
    chk("stray.req",   {31'd0, mem_req_o}, 32'd0);
    chk("stray.stall", {31'd0, stall_o}, 32'd0);
    chk("stray.rdata", rdata_o, 32'h22222222);

    // reset in the middle of a BUSY access
    MEM_ctrl_i = 2'b10; addr_i = 32'h600;
    @(posedge clk); #1;
    chk("rstbusy.req_on", {31'd0, mem_req_o}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b1; MEM_ctrl_i = 2'b00;
    #1;
    chk("rstbusy.req",   {31'd0, mem_req_o}, 32'd0);
    chk("rstbusy.we",    {31'd0, mem_we_o}, 32'd0);
    chk("rstbusy.stall", {31'd0, stall_o}, 32'd0);
    chk("rstbusy.addr",  mem_addr_o, 32'd0);
    chk("rstbusy.rdata", rdata_o, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    chk("rstbusy.idle_req",   {31'd0, mem_req_o}, 32'd0);
    chk("rstbusy.idle_stall", {31'd0, stall_o}, 32'd0);
    chk("sb.empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
